select_sequencer: RTL and testbench
===================================

# select_sequencer

Sequential select-code generator that drives the two select inputs (`s1`, `s0`) of the team's 2-to-4 active-high gate-level decoder. It cycles the select code with a programmable dwell per output and accepts a direct code load over a four-phase req/ack handshake. It also monitors the decoder's four outputs, fed back into the block, and raises a sticky error if the returned pattern is not the expected one-hot word.

## Interface
Parameters:
- `DWELL`, default 4: cycles each code is held during scan; legal range 1..255.
- `CW`, default 8: dwell counter width; must satisfy 2^CW > DWELL.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous assert, active-low; deassertion is synchronised by the system.
- `en` in 1: scan enable.
- `dir` in 1: scan direction; 0 = increment, 1 = decrement.
- `load_req` in 1: load request, held high until `load_ack` is seen.
- `load_val` in 2: code to load, stable while `load_req` is high.
- `load_ack` out 1: load acknowledge.
- `d_fb` in 4: decoder outputs fed back, `d_fb[3:0]` = `{d3,d2,d1,d0}`.
- `err_clr` in 1: clears `err`.
- `s1`, `s0` out 1 each: registered select code; `code = {s1,s0}`.
- `tick` out 1: one-cycle pulse in the first cycle a scanned code is presented.
- `err` out 1: sticky feedback-mismatch flag.

## Operation
- Reset values: `code` = 2'b00, dwell count = 0, `load_ack` = 0, `tick` = 0, `err` = 0, state = IDLE, settle flag = 1.
- States and transitions:
  - IDLE → SCAN when `en` = 1.
  - SCAN → IDLE when `en` = 0.
  - IDLE or SCAN → ACK when `load_req` = 1.
  - ACK → SCAN when `load_req` = 0 and `en` = 1.
  - ACK → IDLE when `load_req` = 0 and `en` = 0.
- SCAN:
  - The dwell count increments every cycle.
  - When count = `DWELL`-1: count ← 0, `code` ← `code`±1 mod 4 (wrap 11→00 up, 00→11 down), `tick` ← 1.
  - `DWELL` = 1 steps every cycle.
- IDLE: `code` and the count are frozen, not cleared. Resuming scan continues the partial dwell.
- Load (from IDLE or SCAN with `load_req` = 1):
  - `code` ← `load_val`, count ← 0, `load_ack` ← 1, state ← ACK.
  - Load has priority over a coincident scan step: the loaded value wins and `tick` stays 0.
- ACK:
  - `code` and count are held.
  - `load_ack` stays 1 until a cycle samples `load_req` = 0; `load_ack` then ← 0 and state leaves ACK.
  - Changes on `load_val` during ACK are ignored.
  - A new load is accepted only after `load_ack` has returned to 0.
- Expected feedback: exactly one `d_fb` bit high, index 3 − code.
  - code 00 → `d_fb` = 4'b1000.
  - code 01 → 4'b0100.
  - code 10 → 4'b0010.
  - code 11 → 4'b0001.
- Checker:
  - The settle flag is set in every cycle the `code` register changes (step or load) and is cleared the next cycle.
  - When the settle flag is 0 and `d_fb` ≠ expected: `err` ← 1.
  - `err_clr` = 1 clears `err`. If a mismatch coincides with `err_clr`, set wins.
  - With `DWELL` = 1 in continuous scan the checker never compares (documented limitation).
- Reset mid-operation (scan or handshake): all state returns to reset values immediately. `load_ack` drops asynchronously, and the requester must restart its handshake.

## Timing
- All outputs are registered. `s1`/`s0` change only on `clk` rising edges.
- Scan step: with `en` high from edge N, the first step occurs at edge N+`DWELL`, then every `DWELL` edges.
- Load latency: `load_req` sampled high at edge N → `code` = `load_val` and `load_ack` = 1 after edge N.
- `load_ack` deassert latency: one edge after `load_req` is sampled low.
- Checker latency: `err` rises one edge after the first unmasked mismatching sample.
- `tick` is high in the same cycle as the new `code`.

## Test plan
- Reset, then `en` = 1, `dir` = 0, `DWELL` = 4: code runs 00,01,10,11,00, holding 4 cycles each; 4 `tick` pulses; `err` = 0 with a correct decoder model on `d_fb`.
- `dir` = 1 from code 00: next code is 11, then 10; `en` = 0 mid-dwell after 2 cycles, wait 10 cycles, `en` = 1: the step occurs after 2 further cycles.
- `load_req` with `load_val` = 10 in the same cycle as a scheduled step from 00: `code` = 10, `tick` = 0, `load_ack` = 1; `load_ack` holds 5 cycles while `load_req` stays high; it drops one edge after `load_req` falls; scan resumes from 10 with a full dwell.
- Force `d_fb` = 4'b0000 for one unmasked cycle at code 01: `err` = 1 and stays 1; `err_clr` pulse with a correct `d_fb` gives `err` = 0; `err_clr` coincident with a mismatch leaves `err` = 1.
- Wrong `d_fb` only in the cycle immediately after a step: `err` stays 0 (settle mask).
- Assert `rst_n` low during ACK with `code` = 11: `load_ack`, `code`, `tick`, and `err` are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/select_sequencer.sv
// select_sequencer: drives the {s1,s0} select code of a 2-to-4 active-high
// decoder. Scans the code with a programmable dwell, accepts a direct load
// over a four-phase req/ack handshake, and checks the decoder's returned
// outputs against the expected one-hot word.
module select_sequencer #(
    parameter int DWELL = 4,  // cycles each code is held while scanning (1..255)
    parameter int CW    = 8   // dwell counter width, 2**CW > DWELL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       load_req,
    input  logic [1:0] load_val,
    output logic       load_ack,
    input  logic [3:0] d_fb,
    input  logic       err_clr,
    output logic       s1,
    output logic       s0,
    output logic       tick,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Terminal dwell count: the step happens on the edge that sees this value.
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_e        state_q;
    logic [1:0]    code_q;
    logic [CW-1:0] cnt_q;
    logic          load_ack_q;
    logic          tick_q;
    logic          err_q;
    logic          settle_q;   // high in the cycle a new code is presented

    logic [1:0]    code_step_d;
    logic [3:0]    exp_fb_d;
    logic          mismatch_d;

    // Next scanned code, expected decoder word and unmasked mismatch.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        code_step_d = dir ? (code_q - 2'd1) : (code_q + 2'd1);
        exp_fb_d    = 4'b1000 >> code_q;
        mismatch_d  = !settle_q && (d_fb != exp_fb_d);
    end

    // Control FSM with registered code, count, handshake, tick and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= 2'b00;
            cnt_q      <= '0;
            load_ack_q <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            settle_q   <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so later
            // statements here still see the pre-edge values of every _q register.
            tick_q   <= 1'b0;
            settle_q <= 1'b0;

            unique case (state_q)
                IDLE, SCAN: begin
                    if (load_req) begin
                        // Load beats a coincident scan step; no tick for a load.
                        code_q     <= load_val;
                        cnt_q      <= '0;
                        load_ack_q <= 1'b1;
                        settle_q   <= 1'b1;
                        state_q    <= ACK;
                    end else if (!en) begin
                        // Code and partial dwell are frozen, not cleared.
                        state_q <= IDLE;
                    end else if (state_q == IDLE) begin
                        // Entering scan does not count, so the first step lands DWELL edges later.
                        state_q <= SCAN;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q    <= '0;
                        code_q   <= code_step_d;
                        tick_q   <= 1'b1;
                        settle_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ACK: begin
                    // Code, count and load_val are ignored until the requester drops load_req.
                    if (!load_req) begin
                        load_ack_q <= 1'b0;
                        state_q    <= en ? SCAN : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Sticky error: a mismatch wins over a coincident clear.
            if (mismatch_d) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign s1       = code_q[1];
    assign s0       = code_q[0];
    assign tick     = tick_q;
    assign load_ack = load_ack_q;
    assign err      = err_q;

endmodule

// File: tb/tb_select_sequencer.sv
// Testbench for select_sequencer (DWELL = 4). Directed stimulus pushes the
// hand-computed expected outputs for each clock edge into a queue; a monitor
// pops one entry per falling edge and compares it with the DUT outputs.
module tb_select_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load_req;
    logic [1:0] load_val;
    logic       load_ack;
    logic [3:0] d_fb;
    logic       err_clr;
    logic       s1;
    logic       s0;
    logic       tick;
    logic       err;

    logic       fb_force;   // replaces the decoder output with 4'b0000

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [4:0] v;      // {code[1:0], tick, load_ack, err}
    } exp_item_t;

    exp_item_t exp_q[$];

    select_sequencer #(.DWELL(4), .CW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .load_req (load_req),
        .load_val (load_val),
        .load_ack (load_ack),
        .d_fb     (d_fb),
        .err_clr  (err_clr),
        .s1       (s1),
        .s0       (s0),
        .tick     (tick),
        .err      (err)
    );

    // Correct 2-to-4 active-high decoder on the select lines, with fault injection.
    assign d_fb = fb_force ? 4'b0000 : (4'b1000 >> {s1, s0});

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got code=%b tick=%b ack=%b err=%b, expected code=%b tick=%b ack=%b err=%b",
                     name, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One clock edge: inputs are already set; record what the edge must produce.
    task automatic cyc(input string name, input logic [1:0] code, input logic t,
                       input logic a, input logic e);
        exp_item_t it;
        @(posedge clk);
        it.name = name;
        it.v    = {code, t, a, e};
        exp_q.push_back(it);
        #1;
    endtask

    // Monitor: compare the outputs of the most recent edge, away from the edge.
    always @(negedge clk) begin
        exp_item_t it;
        if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            check(it.name, {s1, s0, tick, load_ack, err}, it.v);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        dir      = 1'b0;
        load_req = 1'b0;
        load_val = 2'b00;
        err_clr  = 1'b0;
        fb_force = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {s1, s0, tick, load_ack, err}, 5'b00_0_0_0);
        rst_n = 1'b1;

        // Scan up: 00,01,10,11,00 with 4-cycle dwell, tick on each new code.
        en = 1'b1;
        cyc("en_edge", 2'b00, 0, 0, 0);
        repeat (3) cyc("dwell_00", 2'b00, 0, 0, 0);
        cyc("step_01", 2'b01, 1, 0, 0);
        repeat (3) cyc("dwell_01", 2'b01, 0, 0, 0);
        cyc("step_10", 2'b10, 1, 0, 0);
        repeat (3) cyc("dwell_10", 2'b10, 0, 0, 0);
        cyc("step_11", 2'b11, 1, 0, 0);
        repeat (3) cyc("dwell_11", 2'b11, 0, 0, 0);
        cyc("wrap_up_00", 2'b00, 1, 0, 0);

        // Scan down from 00: wraps to 11, pause mid-dwell, resume partial dwell.
        dir = 1'b1;
        repeat (3) cyc("down_dwell_00", 2'b00, 0, 0, 0);
        cyc("wrap_down_11", 2'b11, 1, 0, 0);
        repeat (2) cyc("down_dwell_11", 2'b11, 0, 0, 0);
        en = 1'b0;
        repeat (10) cyc("idle_hold_11", 2'b11, 0, 0, 0);
        en = 1'b1;
        repeat (2) cyc("resume_partial", 2'b11, 0, 0, 0);
        cyc("resume_step_10", 2'b10, 1, 0, 0);
        repeat (3) cyc("down_dwell_10", 2'b10, 0, 0, 0);
        cyc("down_step_01", 2'b01, 1, 0, 0);
        repeat (3) cyc("down_dwell_01", 2'b01, 0, 0, 0);
        cyc("down_step_00", 2'b00, 1, 0, 0);
        repeat (3) cyc("pre_load_00", 2'b00, 0, 0, 0);

        // Load 10 on the edge of a scheduled step: load wins, no tick.
        dir      = 1'b0;
        load_req = 1'b1;
        load_val = 2'b10;
        cyc("load_wins", 2'b10, 0, 1, 0);
        load_val = 2'b01;   // ignored during ACK
        repeat (4) cyc("ack_hold", 2'b10, 0, 1, 0);
        load_req = 1'b0;
        cyc("ack_drop", 2'b10, 0, 0, 0);
        repeat (3) cyc("post_load_dwell", 2'b10, 0, 0, 0);
        cyc("post_load_step_11", 2'b11, 1, 0, 0);

        // Feedback error at code 01, sticky, clear, and set-beats-clear.
        repeat (3) cyc("dwell_11b", 2'b11, 0, 0, 0);
        cyc("step_00b", 2'b00, 1, 0, 0);
        repeat (3) cyc("dwell_00b", 2'b00, 0, 0, 0);
        cyc("step_01b", 2'b01, 1, 0, 0);
        cyc("dwell_01b", 2'b01, 0, 0, 0);
        fb_force = 1'b1;
        cyc("err_set", 2'b01, 0, 0, 1);
        fb_force = 1'b0;
        cyc("err_sticky", 2'b01, 0, 0, 1);
        cyc("err_sticky_step", 2'b10, 1, 0, 1);
        err_clr = 1'b1;
        cyc("err_clear", 2'b10, 0, 0, 0);
        fb_force = 1'b1;
        cyc("clr_vs_mismatch", 2'b10, 0, 0, 1);
        err_clr  = 1'b0;
        fb_force = 1'b0;
        cyc("err_held", 2'b10, 0, 0, 1);
        cyc("step_11_err", 2'b11, 1, 0, 1);
        err_clr = 1'b1;
        cyc("err_clear2", 2'b11, 0, 0, 0);
        err_clr = 1'b0;
        repeat (2) cyc("dwell_11c", 2'b11, 0, 0, 0);
        cyc("step_00c", 2'b00, 1, 0, 0);

        // Wrong feedback only in the settle cycle after a step is masked.
        fb_force = 1'b1;
        cyc("settle_mask", 2'b00, 0, 0, 0);
        fb_force = 1'b0;

        // Load 11, raise err during ACK, then asynchronous reset mid-cycle.
        load_req = 1'b1;
        load_val = 2'b11;
        cyc("load_11", 2'b11, 0, 1, 0);
        load_val = 2'b00;
        cyc("ack_hold_11", 2'b11, 0, 1, 0);
        fb_force = 1'b1;
        cyc("err_in_ack", 2'b11, 0, 1, 1);
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        fb_force = 1'b0;
        load_req = 1'b0;
        en       = 1'b0;
        #1;
        check("async_reset", {s1, s0, tick, load_ack, err}, 5'b00_0_0_0);
        @(posedge clk);
        #1;
        check("reset_hold", {s1, s0, tick, load_ack, err}, 5'b00_0_0_0);
        rst_n = 1'b1;
        repeat (2) cyc("post_reset_idle", 2'b00, 0, 0, 0);

        // Every expected entry must have been consumed by the monitor.
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
